// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencing FSM and the datapath/memory port.
// The controller sits on the master side. The datapath sits on the slave side.
interface multicycle_ctrl_if;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       flag_write;
    logic       branch_link;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       illegal;
    logic       bus_fault;
    logic [3:0] state;

    modport master (
        input  op, funct, rd, cond_ex, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, reg_write, flag_write,
               branch_link, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, illegal, bus_fault, state
    );

    modport slave (
        output op, funct, rd, cond_ex, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, reg_write, flag_write,
               branch_link, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, illegal, bus_fault, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle ARM core: fetch, decode, execute, memory, writeback.
// Outputs are decoded from state. Only the fetch strobes and the timeout path look at mem_ready.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset_n,
    multicycle_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic             dp_writes_reg;
    logic             unused_funct;

    assign unused_funct = ^bus.funct[2:1];

    // The memory-wait states share a single cycle counter.
    // A timeout fires on the last permitted wait cycle when the memory is still not ready.
    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout = waiting && !bus.mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // TST/TEQ/CMP/CMN (opcode 10xx) only update flags.
    assign dp_writes_reg = (bus.funct[4:3] != 2'b10);

    assign bus.state = reset_n ? state_q : 4'd0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if ((state_d != state_q) || timeout) begin
                wait_cnt <= '0;
            end else if (waiting && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.reg_write   = 1'b0;
        bus.flag_write  = 1'b0;
        bus.branch_link = 1'b0;
        bus.adr_src     = 1'b0;
        bus.alu_src_a   = 2'd0;
        bus.alu_src_b   = 2'd0;
        bus.alu_op      = 1'b0;
        bus.result_src  = 2'd0;
        bus.illegal     = 1'b0;
        bus.bus_fault   = timeout;

        case (state_q)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alu_src_a  = 2'd1;
                bus.alu_src_b  = 2'd2;
                bus.result_src = 2'd2;
                if (!timeout && bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_a  = 2'd1;
                bus.alu_src_b  = 2'd2;
                bus.result_src = 2'd2;
                if (!bus.cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (bus.op)
                        2'b00:   state_d = bus.funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: begin
                            bus.illegal = 1'b1;
                            state_d     = FETCH;
                        end
                    endcase
                end
            end
            MEMADR: begin
                bus.alu_src_a = 2'd0;
                bus.alu_src_b = 2'd1;
                state_d       = bus.funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (timeout) begin
                    state_d = FETCH;
                end else if (bus.mem_ready) begin
                    state_d = MEMWB;
                end
            end
            MEMWB: begin
                bus.result_src = 2'd1;
                bus.reg_write  = 1'b1;
                bus.pc_write   = (bus.rd == 4'd15);
                state_d        = FETCH;
            end
            MEMWR: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                bus.mem_we  = !timeout;
                if (timeout || bus.mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXECR: begin
                bus.alu_src_a = 2'd0;
                bus.alu_src_b = 2'd0;
                bus.alu_op    = 1'b1;
                state_d       = ALUWB;
            end
            EXECI: begin
                bus.alu_src_a = 2'd0;
                bus.alu_src_b = 2'd1;
                bus.alu_op    = 1'b1;
                state_d       = ALUWB;
            end
            ALUWB: begin
                bus.result_src = 2'd0;
                bus.flag_write = bus.funct[0];
                bus.reg_write  = dp_writes_reg;
                bus.pc_write   = dp_writes_reg && (bus.rd == 4'd15);
                state_d        = FETCH;
            end
            BRANCH: begin
                bus.alu_src_a   = 2'd0;
                bus.alu_src_b   = 2'd1;
                bus.result_src  = 2'd2;
                bus.pc_write    = 1'b1;
                bus.branch_link = bus.funct[4];
                bus.reg_write   = bus.funct[4];
                state_d         = FETCH;
            end
            default: begin
                bus.bus_fault = 1'b0;
                state_d       = FETCH;
            end
        endcase

        // While in reset, every strobe and select is held low, whatever the state register holds.
        if (!reset_n) begin
            bus.mem_req     = 1'b0;
            bus.mem_we      = 1'b0;
            bus.ir_write    = 1'b0;
            bus.pc_write    = 1'b0;
            bus.reg_write   = 1'b0;
            bus.flag_write  = 1'b0;
            bus.branch_link = 1'b0;
            bus.adr_src     = 1'b0;
            bus.alu_src_a   = 2'd0;
            bus.alu_src_b   = 2'd0;
            bus.alu_op      = 1'b0;
            bus.result_src  = 2'd0;
            bus.illegal     = 1'b0;
            bus.bus_fault   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle traces are built from
// the instruction's fields and memory wait counts, then replayed against the DUT cycle by cycle.
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 16;

    typedef struct packed {
        logic [3:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       flag_write;
        logic       branch_link;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
        logic       illegal;
        logic       bus_fault;
    } obs_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic       cond;
        logic       ready;
        obs_t       exp;
    } step_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    step_t      plan[$];
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic [3:0] cur_rd;
    logic       cur_cond;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic obs_t observe();
        obs_t o;
        o.state       = bus.state;
        o.mem_req     = bus.mem_req;
        o.mem_we      = bus.mem_we;
        o.ir_write    = bus.ir_write;
        o.pc_write    = bus.pc_write;
        o.reg_write   = bus.reg_write;
        o.flag_write  = bus.flag_write;
        o.branch_link = bus.branch_link;
        o.adr_src     = bus.adr_src;
        o.alu_src_a   = bus.alu_src_a;
        o.alu_src_b   = bus.alu_src_b;
        o.alu_op      = bus.alu_op;
        o.result_src  = bus.result_src;
        o.illegal     = bus.illegal;
        o.bus_fault   = bus.bus_fault;
        return o;
    endfunction

    function automatic logic rand_bit();
        return ($urandom & 1) != 0;
    endfunction

    function automatic void push_step(input obs_t e, input logic ready);
        step_t s;
        s.op    = cur_op;
        s.funct = cur_funct;
        s.rd    = cur_rd;
        s.cond  = cur_cond;
        s.ready = ready;
        s.exp   = e;
        plan.push_back(s);
    endfunction

    // Memory access lasting 'waits' not-ready cycles; returns 0 when it ends in a bus fault
    function automatic bit queue_access(input obs_t base, input obs_t done, input int waits);
        obs_t e;
        int   n;
        n = (waits >= MEM_TIMEOUT) ? MEM_TIMEOUT - 1 : waits;
        for (int i = 0; i < n; i++) push_step(base, 1'b0);
        if (waits >= MEM_TIMEOUT) begin
            e           = base;
            e.mem_we    = 1'b0;
            e.bus_fault = 1'b1;
            push_step(e, 1'b0);
            return 1'b0;
        end
        push_step(done, 1'b1);
        return 1'b1;
    endfunction

    function automatic void queue_instr(input logic [1:0] op, input logic [5:0] funct,
                                        input logic [3:0] rd, input logic cond,
                                        input int fetch_wait, input int mem_wait);
        obs_t e;
        obs_t d;
        cur_op    = op;
        cur_funct = funct;
        cur_rd    = rd;
        cur_cond  = cond;

        e            = '0;
        e.mem_req    = 1'b1;
        e.alu_src_a  = 2'd1;
        e.alu_src_b  = 2'd2;
        e.result_src = 2'd2;
        d            = e;
        d.ir_write   = 1'b1;
        d.pc_write   = 1'b1;
        if (!queue_access(e, d, fetch_wait)) return;

        e            = '0;
        e.state      = 4'd1;
        e.alu_src_a  = 2'd1;
        e.alu_src_b  = 2'd2;
        e.result_src = 2'd2;
        e.illegal    = cond && (op == 2'b11);
        push_step(e, rand_bit());
        if (!cond || (op == 2'b11)) return;

        case (op)
            2'b01: begin
                e           = '0;
                e.state     = 4'd2;
                e.alu_src_b = 2'd1;
                push_step(e, rand_bit());
                e         = '0;
                e.state   = funct[0] ? 4'd3 : 4'd5;
                e.mem_req = 1'b1;
                e.adr_src = 1'b1;
                e.mem_we  = !funct[0];
                if (!queue_access(e, e, mem_wait)) return;
                if (funct[0]) begin
                    e            = '0;
                    e.state      = 4'd4;
                    e.result_src = 2'd1;
                    e.reg_write  = 1'b1;
                    e.pc_write   = (rd == 4'd15);
                    push_step(e, rand_bit());
                end
            end
            2'b00: begin
                e           = '0;
                e.state     = funct[5] ? 4'd7 : 4'd6;
                e.alu_src_b = funct[5] ? 2'd1 : 2'd0;
                e.alu_op    = 1'b1;
                push_step(e, rand_bit());
                e            = '0;
                e.state      = 4'd8;
                e.flag_write = funct[0];
                e.reg_write  = (funct[4:3] != 2'b10);
                e.pc_write   = e.reg_write && (rd == 4'd15);
                push_step(e, rand_bit());
            end
            default: begin
                e             = '0;
                e.state       = 4'd9;
                e.alu_src_b   = 2'd1;
                e.result_src  = 2'd2;
                e.pc_write    = 1'b1;
                e.branch_link = funct[4];
                e.reg_write   = funct[4];
                push_step(e, rand_bit());
            end
        endcase
    endfunction

    task automatic drive_step(input step_t s);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.op        = s.op;
        bus.funct     = s.funct;
        bus.rd        = s.rd;
        bus.cond_ex   = s.cond;
        bus.mem_ready = s.ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got;
        step_t s;
        int n = 0;
        reset_n       = 1'b0;
        bus.op        = 2'b00;
        bus.funct     = 6'b0;
        bus.rd        = 4'd0;
        bus.cond_ex   = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                @(negedge clk);
            end
            got = observe();
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h expected %h", i, got, obs_t'(0));
            end
        end
        queue_instr(2'b00, 6'b001000, 4'd1, 1'b1, 0, 0);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL reset_release step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_alu();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b00, 6'b001000, 4'd1, 1'b1, 1, 0);
        queue_instr(2'b00, 6'b101001, 4'd15, 1'b1, 2, 0);
        for (int i = 0; i < 6; i++)
            queue_instr(2'b00, 6'($urandom), 4'($urandom), 1'b1, $urandom_range(0, 2), 0);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL alu step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_load_store();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b01, 6'b011001, 4'd15, 1'b1, 0, 3);
        queue_instr(2'b01, 6'b011000, 4'd2, 1'b1, 1, 2);
        for (int i = 0; i < 4; i++)
            queue_instr(2'b01, 6'($urandom), 4'($urandom), 1'b1, $urandom_range(0, 2),
                        $urandom_range(0, 6));
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL load_store step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b10, 6'b110000, 4'd0, 1'b1, 0, 0);
        queue_instr(2'b10, 6'b110000, 4'd0, 1'b0, 0, 0);
        queue_instr(2'b10, 6'b100000, 4'($urandom), 1'b1, 1, 0);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL branch step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_cmp_illegal();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b00, 6'b010101, 4'd0, 1'b1, 0, 0);
        queue_instr(2'b11, 6'($urandom), 4'($urandom), 1'b1, 0, 0);
        queue_instr(2'b11, 6'($urandom), 4'($urandom), 1'b0, 0, 0);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL cmp_illegal step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_timeout();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b01, 6'b011000, 4'd4, 1'b1, 0, MEM_TIMEOUT + 4);
        queue_instr(2'b00, 6'b001000, 4'd1, 1'b1, 0, 0);
        queue_instr(2'b01, 6'b011001, 4'd5, 1'b1, 0, MEM_TIMEOUT);
        queue_instr(2'b01, 6'b011001, 4'd6, 1'b1, 0, MEM_TIMEOUT - 1);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL timeout step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_access();
        obs_t got;
        step_t s;
        int n = 0;
        queue_instr(2'b01, 6'b011001, 4'd3, 1'b1, 0, 10);
        for (int i = 0; i < 5; i++) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_pre step %0d: got %h expected %h", i, got, s.exp);
            end
        end
        plan.delete();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            reset_n       = 1'b0;
            bus.mem_ready = 1'b0;
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("[TB] FAIL mid_reset_outputs cycle %0d: got %h expected %h", i, got, obs_t'(0));
            end
        end
        queue_instr(2'b00, 6'b001000, 4'd7, 1'b1, 1, 0);
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL mid_reset_after step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        step_t s;
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            queue_instr(2'($urandom_range(0, 3)), 6'($urandom),
                        ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom),
                        $urandom_range(0, 7) != 0, $urandom_range(0, 3),
                        ($urandom_range(0, 9) == 0) ? $urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 4)
                                                    : $urandom_range(0, 4));
        end
        while (plan.size() != 0) begin
            s   = plan.pop_front();
            drive_step(s);
            got = observe();
            checks++;
            if (got !== s.exp) begin
                errors++;
                $display("[TB] FAIL back_to_back step %0d: got %h expected %h", n, got, s.exp);
            end
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_cmp_illegal();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
